// File: rtl/vga_timing_param.sv
// vga_timing_param: parameterised VGA sync/pixel-counter generator running off clk_50.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_timing_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 10
) (
    input  logic          clk_50,
    input  logic          rst_n,
    output logic          vga_clk,
    output logic          pix_en,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          in_display_area,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_count
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    logic [DW-1:0] div, div_nxt;
    logic          x_wrap, y_wrap;

    // Decodes are gated by rst_n so outputs reach reset levels asynchronously.
    always_comb begin
        pix_en          = div == DW'(CLK_DIV - 1);
        div_nxt         = pix_en ? '0 : div + DW'(1);
        x_wrap          = pixel_x == CW'(H_TOTAL - 1);
        y_wrap          = pixel_y == CW'(V_TOTAL - 1);
        vga_hs          = (rst_n && pixel_x >= CW'(H_ACTIVE + H_FP) &&
                           pixel_x < CW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
        vga_vs          = (rst_n && pixel_y >= CW'(V_ACTIVE + V_FP) &&
                           pixel_y < CW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
        in_display_area = rst_n && pixel_x < CW'(H_ACTIVE) && pixel_y < CW'(V_ACTIVE);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            vga_clk     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            vga_clk     <= div_nxt >= DW'(CLK_DIV / 2);
            line_start  <= pix_en && x_wrap;
            frame_start <= pix_en && x_wrap && y_wrap;
            if (pix_en) begin
                pixel_x <= x_wrap ? '0 : pixel_x + CW'(1);
                if (x_wrap)
                    pixel_y <= y_wrap ? '0 : pixel_y + CW'(1);
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)
            frame_count <= '0;
        else if (pix_en && x_wrap && y_wrap)
            frame_count <= frame_count + 8'd1;
    end
`endif
endmodule
